// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - request/response channel bundle between the execute stage and muldiv_unit
interface muldiv_unit_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       funct3;
  logic [XLEN-1:0]  op_a;
  logic [XLEN-1:0]  op_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  result;
  logic [TAG_W-1:0] out_tag;
  logic             out_illegal;
  logic             busy;

  modport master (
    output flush, in_valid, funct3, op_a, op_b, in_tag, out_ready,
    input  in_ready, out_valid, result, out_tag, out_illegal, busy
  );

  modport slave (
    input  flush, in_valid, funct3, op_a, op_b, in_tag, out_ready,
    output in_ready, out_valid, result, out_tag, out_illegal, busy
  );
endinterface

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M/RV64M shift-add multiplier and restoring divider on one accumulator
// Define MULDIV_DIV_EN to build the divider; without it funct3 1xx returns out_illegal.
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input logic          clk,
  input logic          rst,
  muldiv_unit_if.slave bus
);
  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_n;

  logic [CW-1:0]    cnt;
  logic [2:0]       fn;
  logic             neg;
  logic [XLEN-1:0]  acc;
  logic [XLEN-1:0]  mq;
  logic [XLEN-1:0]  bm;
  logic             out_valid_q;
  logic             out_illegal_q;
  logic [XLEN-1:0]  result_q;
  logic [TAG_W-1:0] out_tag_q;

  logic             accept;
  logic             a_signed, b_signed, a_neg, b_neg, neg_in;
  logic [XLEN-1:0]  a_mag, b_mag;
  logic             special, spec_illegal;
  logic [XLEN-1:0]  spec_result;
  logic [XLEN-1:0]  addend;
  logic [XLEN:0]    mul_sum;
  logic [XLEN-1:0]  acc_n, mq_n, fin;
  logic [2*XLEN-1:0] prod;

  assign accept          = bus.in_valid && (state == IDLE) && !bus.flush;
  assign bus.in_ready    = (state == IDLE);
  assign bus.busy        = (state != IDLE);
  assign bus.out_valid   = out_valid_q;
  assign bus.result      = result_q;
  assign bus.out_tag     = out_tag_q;
  assign bus.out_illegal = out_illegal_q;

  // Operands become magnitudes at accept; the sign is reapplied in the last CALC cycle.
  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    if (bus.funct3[2]) begin
      a_signed = ~bus.funct3[0];
      b_signed = ~bus.funct3[0];
    end else begin
      a_signed = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010);
      b_signed = (bus.funct3 == 3'b001);
    end
    a_neg  = a_signed && bus.op_a[XLEN-1];
    b_neg  = b_signed && bus.op_b[XLEN-1];
    a_mag  = a_neg ? -bus.op_a : bus.op_a;
    b_mag  = b_neg ? -bus.op_b : bus.op_b;
    neg_in = (bus.funct3[2] && bus.funct3[1]) ? a_neg : (a_neg ^ b_neg);
  end

`ifdef MULDIV_DIV_EN
  always_comb begin
    special      = 1'b0;
    spec_result  = '0;
    spec_illegal = 1'b0;
    if (bus.funct3[2]) begin
      if (bus.op_b == '0) begin
        special     = 1'b1;
        spec_result = bus.funct3[1] ? bus.op_a : '1;
      end else if (a_signed && (bus.op_a == INT_MIN) && (bus.op_b == '1)) begin
        special     = 1'b1;
        spec_result = bus.funct3[1] ? '0 : bus.op_a;
      end
    end
  end
`else
  assign special      = bus.funct3[2];
  assign spec_result  = '0;
  assign spec_illegal = bus.funct3[2];
`endif

`ifdef MULDIV_DIV_EN
  logic [XLEN:0] shifted;
`endif

  always_comb begin
    addend  = mq[0] ? bm : '0;
    mul_sum = {1'b0, acc} + {1'b0, addend};
    acc_n   = mul_sum[XLEN:1];
    mq_n    = {mul_sum[0], mq[XLEN-1:1]};
`ifdef MULDIV_DIV_EN
    shifted = {acc, mq[XLEN-1]};
    if (fn[2]) begin
      // Remainder stays below the divisor, so the low XLEN bits of the difference are exact.
      if (shifted >= {1'b0, bm}) begin
        acc_n = shifted[XLEN-1:0] - bm;
        mq_n  = {mq[XLEN-2:0], 1'b1};
      end else begin
        acc_n = shifted[XLEN-1:0];
        mq_n  = {mq[XLEN-2:0], 1'b0};
      end
    end
`endif
    prod = {acc_n, mq_n};
    if (neg) prod = -prod;
    fin = (fn == 3'b000) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
`ifdef MULDIV_DIV_EN
    if (fn[2]) begin
      fin = fn[1] ? acc_n : mq_n;
      if (neg) fin = -fin;
    end
`endif
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = special ? DONE : CALC;
      CALC:    if (cnt == '0) state_n = DONE;
      DONE:    if (bus.out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (bus.flush) state_n = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt           <= '0;
      fn            <= '0;
      neg           <= 1'b0;
      acc           <= '0;
      mq            <= '0;
      bm            <= '0;
      out_valid_q   <= 1'b0;
      out_illegal_q <= 1'b0;
      result_q      <= '0;
      out_tag_q     <= '0;
    end else begin
      out_valid_q <= (state_n == DONE);
      if (accept) begin
        fn        <= bus.funct3;
        neg       <= neg_in;
        bm        <= b_mag;
        acc       <= '0;
        mq        <= a_mag;
        cnt       <= CW'(XLEN-1);
        out_tag_q <= bus.in_tag;
        if (special) begin
          result_q      <= spec_result;
          out_illegal_q <= spec_illegal;
        end
      end else if ((state == CALC) && !bus.flush) begin
        acc <= acc_n;
        mq  <= mq_n;
        if (cnt == '0) begin
          result_q      <= fin;
          out_illegal_q <= 1'b0;
        end else begin
          cnt <= cnt - 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - scoreboard bench for muldiv_unit at XLEN=32, expectations follow MULDIV_DIV_EN
`timescale 1ns/1ps
module tb_muldiv_unit;
  localparam int XLEN  = 32;
  localparam int TAG_W = 5;
`ifdef MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  tag;
    logic        ill;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];

  muldiv_unit_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

  muldiv_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Monitor: every accepted result is compared against the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_output", {63'd0, bus.out_valid}, 64'd0);
      end else begin
        e = sb.pop_front();
        check("result", {32'd0, bus.result}, {32'd0, e.res});
        check("out_tag", {59'd0, bus.out_tag}, {59'd0, e.tag});
        check("out_illegal", {63'd0, bus.out_illegal}, {63'd0, e.ill});
      end
    end
  end

  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] t, input logic [31:0] er, input logic ei,
                       input int elat, input int hold);
    int lat;
    @(posedge clk); #1;
    check("in_ready_idle", {63'd0, bus.in_ready}, 64'd1);
    bus.funct3    = f;
    bus.op_a      = a;
    bus.op_b      = b;
    bus.in_tag    = t;
    bus.in_valid  = 1'b1;
    bus.out_ready = (hold == 0);
    sb.push_back(exp_t'{res: er, tag: t, ill: ei});
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("edges_after_accept", 64'(lat), 64'(elat));
    for (int i = 0; i < hold; i++) begin
      check("hold_result", {32'd0, bus.result}, {32'd0, er});
      check("hold_tag", {59'd0, bus.out_tag}, {59'd0, t});
      check("hold_in_ready", {63'd0, bus.in_ready}, 64'd0);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("drained", {63'd0, bus.out_valid}, 64'd0);
  endtask

  task automatic div_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] t, input logic [31:0] er, input int elat);
    if (DIV_EN) do_op(f, a, b, t, er, 1'b0, elat, 0);
    else        do_op(f, a, b, t, 32'h0, 1'b1, 0, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst           = 1'b1;
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.funct3    = 3'b000;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("rst_busy", {63'd0, bus.busy}, 64'd0);
    check("rst_result", {32'd0, bus.result}, 64'd0);
    check("rst_out_tag", {59'd0, bus.out_tag}, 64'd0);
    check("rst_out_illegal", {63'd0, bus.out_illegal}, 64'd0);
    rst = 1'b0;

    do_op(3'b000, 32'd7, 32'hFFFF_FFFD, 5'h0A, 32'hFFFF_FFEB, 1'b0, 32, 0);
    do_op(3'b001, 32'h8000_0000, 32'h8000_0000, 5'h01, 32'h4000_0000, 1'b0, 32, 0);
    do_op(3'b011, 32'h8000_0000, 32'h8000_0000, 5'h02, 32'h4000_0000, 1'b0, 32, 0);
    do_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'h03, 32'hFFFF_FFFF, 1'b0, 32, 0);
    do_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'h04, 32'hFFFF_FFFE, 1'b0, 32, 0);
    do_op(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'h05, 32'h0000_0001, 1'b0, 32, 0);

    div_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'h06, 32'h8000_0000, 0);
    div_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'h07, 32'h0000_0000, 0);
    div_op(3'b101, 32'd5, 32'd0, 5'h08, 32'hFFFF_FFFF, 0);
    div_op(3'b111, 32'd5, 32'd0, 5'h09, 32'd5, 0);
    div_op(3'b110, 32'hFFFF_FFF9, 32'd2, 5'h0B, 32'hFFFF_FFFF, 32);
    div_op(3'b100, 32'hFFFF_FFF9, 32'd2, 5'h0C, 32'hFFFF_FFFD, 32);
    div_op(3'b101, 32'd100, 32'd7, 5'h0D, 32'd14, 32);
    div_op(3'b111, 32'd100, 32'd7, 5'h0E, 32'd2, 32);
    div_op(3'b101, 32'd9, 32'd3, 5'h0F, 32'd3, 32);

    do_op(3'b000, 32'd3, 32'd3, 5'h1F, 32'd9, 1'b0, 32, 10);

    @(posedge clk); #1;
    bus.funct3   = 3'b000;
    bus.op_a     = 32'd5;
    bus.op_b     = 32'd6;
    bus.in_tag   = 5'h11;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    check("calc_in_ready", {63'd0, bus.in_ready}, 64'd0);
    check("calc_busy", {63'd0, bus.busy}, 64'd1);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    check("flush_busy", {63'd0, bus.busy}, 64'd0);
    check("flush_in_ready", {63'd0, bus.in_ready}, 64'd1);
    n = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.out_valid) n++;
    end
    check("flush_no_output", 64'(n), 64'd0);

    bus.in_valid = 1'b1;
    bus.flush    = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    check("flush_blocks_accept", {63'd0, bus.busy}, 64'd0);

    do_op(3'b000, 32'd5, 32'd6, 5'h12, 32'd30, 1'b0, 32, 0);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
